wave_key_ctrl: RTL
==================

Name: wave_key_ctrl

Overview:
- Upstream control stage for the multi-waveform DAC generator.
- Turns two raw, bouncing push-buttons (NEXT, PREV) into the 3-bit waveform select code that the generator consumes.
- Mode codes: 0 = sine, 1 = sawtooth, 2 = square, 3 = triangle.
- Also drives one-hot indicator LEDs and emits a one-cycle pulse on every mode change.

Parameters:
- DEBOUNCE_CYC, 1000000, consecutive stable cycles required to accept a key level change (20 ms at 50 MHz).
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYC.
- NUM_MODES, 4, number of waveform modes; select wraps modulo NUM_MODES.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous reset, active-high (1 = reset). The name follows codebase convention; it is not active-low.
- key_next_n  input  1  raw NEXT button, asynchronous, 0 = pressed.
- key_prev_n  input  1  raw PREV button, asynchronous, 0 = pressed.
- key_multiwave  output  3  waveform select to the generator, range 0..NUM_MODES-1.
- wave_led  output  4  one-hot mode indicator; bit k is high when key_multiwave = k.
- mode_chg  output  1  single-cycle pulse, high in the cycle key_multiwave takes a new value.

Behaviour:
- Reset is synchronous, active-high, and sampled on the clk rising edge. Reset values:
  - key_multiwave = 0, wave_led = 4'b0001, mode_chg = 0.
  - Sync flops = 1, debounced levels = 1 (released), debounce counters = 0.
- Synchronizer: each raw key passes through a 2-flop synchronizer before any other logic.
- Debounce, per key:
  - If the synchronized level equals the debounced level, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYC-1 and the levels still differ, the debounced level takes the synchronized value and the counter clears.
  - A single cycle of agreement inside the window restarts the count.
- Press detect: press pulse = registered debounced 1->0 transition, one cycle wide. Release (0->1) generates no pulse.
- Mode update, in the cycle after the press pulse:
  - Only NEXT pulsed: key_multiwave <= (key_multiwave == NUM_MODES-1) ? 0 : key_multiwave+1.
  - Only PREV pulsed: key_multiwave <= (key_multiwave == 0) ? NUM_MODES-1 : key_multiwave-1.
  - Both pulsed in the same cycle: no change, mode_chg stays 0.
  - Neither pulsed: hold.
- mode_chg: registered, high exactly in the cycle key_multiwave first shows the new value.
- wave_led: registered decode of the next key_multiwave value, so it updates in the same cycle as key_multiwave.
- Latency: raw key held low from cycle T gives the new key_multiwave at cycle T + DEBOUNCE_CYC + 4.
  - 2 cycles sync, DEBOUNCE_CYC cycles debounce, 1 cycle edge detect, 1 cycle mode register.
- Holding a key gives exactly one step; there is no auto-repeat. Another step needs a debounced release and a new press.
- Reset mid-debounce: all counters clear. After reset is released, a still-held key counts as a new press after a full window, because the debounced level resets to 1.
- key_multiwave never leaves 0..NUM_MODES-1, including across wrap-around in both directions.

Decomposition:
- Shared package wave_pkg holds:
  - Mode constants WAVE_SIN=0, WAVE_SAW=1, WAVE_SQR=2, WAVE_TRI=3.
  - NUM_MODES and the select width of 3, shared with the generator.
- One sub-module, key_debounce, instantiated twice (NEXT, PREV).
  - Contains: synchronizer, counter, debounced level, press pulse output.
  - Parameters: DEBOUNCE_CYC, CNT_W.
- The top level holds the mode register, the LED decode and mode_chg.

Test Plan (DEBOUNCE_CYC=16 for simulation):
- Reset behaviour: assert rst_n for 3 cycles with both keys released -> key_multiwave=0, wave_led=0001, mode_chg=0. Deassert -> all outputs hold indefinitely.
- Clean NEXT press: key_next_n=0 from cycle T, held 40 cycles -> key_multiwave=1, wave_led=0010, mode_chg high only at T+20. Four presses total step the mode 1,2,3,0 (wrap).
- PREV wrap and bounce rejection:
  - From mode 0, PREV low with 3-cycle toggles every 5 cycles for 30 cycles, then steady low -> no change during bounce.
  - Exactly one step to mode 3, 20 cycles after steady low begins.
- Short glitch: key_next_n low for 15 cycles, then high -> no mode change, mode_chg never asserted.
- Simultaneous press: both keys low in the same cycle and held -> key_multiwave unchanged, mode_chg stays 0. Releasing both and pressing NEXT alone -> normal single step.
- Reset mid-operation: NEXT held; rst_n asserted at counter value 10 for 1 cycle, key still held -> step occurs 20 cycles after reset deassertion, from mode 0 to mode 1.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared definitions between the key controller and the waveform generator:
// mode codes, number of modes and the select bus width.
package wave_pkg;
  localparam int SEL_W     = 3;
  localparam int NUM_MODES = 4;

  localparam logic [SEL_W-1:0] WAVE_SIN = 3'd0;
  localparam logic [SEL_W-1:0] WAVE_SAW = 3'd1;
  localparam logic [SEL_W-1:0] WAVE_SQR = 3'd2;
  localparam logic [SEL_W-1:0] WAVE_TRI = 3'd3;
endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, counter debounce, and a one-cycle
// registered press pulse on the debounced 1->0 transition.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int CNT_W        = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);
  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_level_d;
  logic             r_press;
  logic             w_sync;

  assign w_sync  = r_sync[1];
  assign o_press = r_press;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_sync    <= 2'b11;
      r_cnt     <= '0;
      r_level   <= 1'b1;
      r_level_d <= 1'b1;
      r_press   <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_key_n};
      r_level_d <= r_level;
      r_press   <= r_level_d & ~r_level;
      // Any cycle of agreement restarts the stability window.
      if (w_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        r_level <= w_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/wave_key_ctrl.sv
// Waveform select controller: NEXT/PREV presses step a wrapping mode register,
// with one-hot LEDs and a one-cycle mode-change pulse.
module wave_key_ctrl
  import wave_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int CNT_W        = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_next_n,
  input  logic                 key_prev_n,
  output logic [SEL_W-1:0]     key_multiwave,
  output logic [NUM_MODES-1:0] wave_led,
  output logic                 mode_chg
);
  logic                 w_next_press;
  logic                 w_prev_press;
  logic [SEL_W-1:0]     w_next_mode;
  logic                 w_step;
  logic [NUM_MODES-1:0] w_led;
  logic [SEL_W-1:0]     r_mode;
  logic [NUM_MODES-1:0] r_led;
  logic                 r_chg;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_next (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key_n (key_next_n),
    .o_press (w_next_press)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_prev (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key_n (key_prev_n),
    .o_press (w_prev_press)
  );

  // Simultaneous presses cancel; only a lone pulse moves the mode.
  always_comb begin
    w_next_mode = r_mode;
    w_step      = 1'b0;
    if (w_next_press && !w_prev_press) begin
      w_step      = 1'b1;
      w_next_mode = (r_mode == SEL_W'(NUM_MODES - 1)) ? '0 : r_mode + 1'b1;
    end else if (w_prev_press && !w_next_press) begin
      w_step      = 1'b1;
      w_next_mode = (r_mode == '0) ? SEL_W'(NUM_MODES - 1) : r_mode - 1'b1;
    end
    w_led = '0;
    for (int k = 0; k < NUM_MODES; k++) begin
      w_led[k] = (w_next_mode == SEL_W'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_mode <= WAVE_SIN;
      r_led  <= NUM_MODES'(1);
      r_chg  <= 1'b0;
    end else begin
      r_mode <= w_next_mode;
      r_led  <= w_led;
      r_chg  <= w_step;
    end
  end

  assign key_multiwave = r_mode;
  assign wave_led      = r_led;
  assign mode_chg      = r_chg;
endmodule
